// File: rtl/tm1638_disp_drv_if.sv
// TM1638 display-driver bundle: BCD time digits in, 3-wire serial bus and status out.
// The master modport is the driver side; slave is the digit source / display side.
interface tm1638_disp_drv_if;
   logic [3:0] hour_chuc;
   logic [3:0] hour_dv;
   logic [3:0] min_chuc;
   logic [3:0] min_dv;
   logic [3:0] sec_chuc;
   logic [3:0] sec_dv;
   logic       stb;
   logic       sclk;
   logic       dio;
   logic       busy;
   logic [7:0] data_check;

   modport master (
      input  hour_chuc, hour_dv, min_chuc, min_dv, sec_chuc, sec_dv,
      output stb, sclk, dio, busy, data_check
   );

   modport slave (
      output hour_chuc, hour_dv, min_chuc, min_dv, sec_chuc, sec_dv,
      input  stb, sclk, dio, busy, data_check
   );
endinterface

// File: rtl/tm1638_disp_drv.sv
// Periodic HH-MM-SS frame writer for a TM1638 controller (write-only stb/sclk/dio, LSB first).
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit.
module tm1638_disp_drv #(
   parameter int         CLK_DIV        = 25,
   parameter int         REFRESH_CYCLES = 500000,
   parameter logic [2:0] BRIGHTNESS     = 3'd7
) (
   input  logic              clk_50M,
   input  logic              reset,
   tm1638_disp_drv_if.master bus
);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] STB_SETUP = 3'd1;
   localparam logic [2:0] SHIFT     = 3'd2;
   localparam logic [2:0] BYTE_END  = 3'd3;
   localparam logic [2:0] STB_HOLD  = 3'd4;
   localparam logic [2:0] GAP       = 3'd5;

   localparam int CW = $clog2(2 * CLK_DIV);
   localparam int RW = $clog2(REFRESH_CYCLES + 1);
   localparam logic [CW-1:0] CD_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CD_PRE   = CW'(CLK_DIV - 2);
   localparam logic [CW-1:0] GAP_LAST = CW'(2 * CLK_DIV - 1);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

   localparam logic [7:0] CMD_DATA = 8'h40;
   localparam logic [7:0] CMD_ADDR = 8'hC0;
   localparam logic [7:0] CMD_DISP = {5'b10001, BRIGHTNESS};
   localparam logic [7:0] DASH     = 8'h40;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'h3F;
         4'd1:    seg7 = 8'h06;
         4'd2:    seg7 = 8'h5B;
         4'd3:    seg7 = 8'h4F;
         4'd4:    seg7 = 8'h66;
         4'd5:    seg7 = 8'h6D;
         4'd6:    seg7 = 8'h7D;
         4'd7:    seg7 = 8'h07;
         4'd8:    seg7 = 8'h7F;
         4'd9:    seg7 = 8'h6F;
         default: seg7 = DASH;
      endcase
   endfunction

   logic [2:0]    st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic          ph_q, ph_d;
   logic [1:0]    txn_q, txn_d;
   logic [4:0]    byte_q, byte_d;
   logic [7:0]    sh_q, sh_d;
   logic [RW-1:0] ref_q, ref_d;
   logic          first_q, first_d;
   logic          stb_q, stb_d, sclk_q, sclk_d, dio_q, dio_d, busy_q, busy_d;
   logic [7:0]    dchk_q, dchk_d;
   logic [3:0]    hc_q, hd_q, mc_q, md_q, sc_q, sd_q;
   logic          start;
   logic [3:0]    addr;
   logic [4:0]    last_byte;
   logic [7:0]    hc_seg, cur_byte;

`ifdef LEADING_ZERO_BLANK_EN
   assign hc_seg = (hc_q == 4'd0) ? 8'h00 : seg7(hc_q);
`else
   assign hc_seg = seg7(hc_q);
`endif

   assign start     = (st_q == IDLE) && (first_q || (ref_q == REF_LAST));
   assign addr      = byte_q[3:0] - 4'd1;
   assign last_byte = (txn_q == 2'd1) ? 5'd17 : 5'd1;

   // byte_q counts bytes already loaded, so it indexes the next byte of the transaction
   always_comb begin
      cur_byte = 8'h00;
      if (txn_q == 2'd0)       cur_byte = CMD_DATA;
      else if (txn_q == 2'd2)  cur_byte = CMD_DISP;
      else if (byte_q == 5'd0) cur_byte = CMD_ADDR;
      else if (!addr[0]) begin
         case (addr[3:1])
            3'd0:    cur_byte = hc_seg;
            3'd1:    cur_byte = seg7(hd_q);
            3'd3:    cur_byte = seg7(mc_q);
            3'd4:    cur_byte = seg7(md_q);
            3'd6:    cur_byte = seg7(sc_q);
            3'd7:    cur_byte = seg7(sd_q);
            default: cur_byte = DASH;
         endcase
      end
   end

   always_comb begin
      st_d = st_q;   cnt_d = cnt_q;   bit_d = bit_q;   ph_d = ph_q;
      txn_d = txn_q; byte_d = byte_q; sh_d = sh_q;     first_d = first_q;
      stb_d = stb_q; sclk_d = sclk_q; dio_d = dio_q;   busy_d = busy_q;
      dchk_d = dchk_q;
      if (start)                 ref_d = '0;
      else if (ref_q == REF_LAST) ref_d = ref_q;
      else                       ref_d = ref_q + 1'b1;
      case (st_q)
         IDLE: if (start) begin
            first_d = 1'b0; busy_d = 1'b1; stb_d = 1'b0;
            txn_d = 2'd0; byte_d = 5'd0; cnt_d = '0; st_d = STB_SETUP;
         end
         STB_SETUP, BYTE_END: begin
            if (st_q == BYTE_END) dchk_d = sh_q;
            if (st_q == STB_SETUP && cnt_q != CD_LAST) cnt_d = cnt_q + 1'b1;
            else if (byte_q < last_byte) begin
               sh_d = cur_byte; byte_d = byte_q + 5'd1; bit_d = 3'd0; ph_d = 1'b0;
               sclk_d = 1'b0; dio_d = cur_byte[0]; cnt_d = '0; st_d = SHIFT;
            end else begin
               cnt_d = '0; st_d = STB_HOLD;
            end
         end
         // BYTE_END stands in for the final cycle of bit 7's high phase
         SHIFT: begin
            if (!ph_q) begin
               if (cnt_q == CD_LAST) begin sclk_d = 1'b1; ph_d = 1'b1; cnt_d = '0; end
               else cnt_d = cnt_q + 1'b1;
            end else if (bit_q == 3'd7 && cnt_q == CD_PRE) begin
               cnt_d = '0; st_d = BYTE_END;
            end else if (cnt_q == CD_LAST) begin
               sclk_d = 1'b0; ph_d = 1'b0; cnt_d = '0;
               bit_d = bit_q + 3'd1; dio_d = sh_q[bit_q + 3'd1];
            end else cnt_d = cnt_q + 1'b1;
         end
         STB_HOLD: begin
            if (cnt_q == CD_LAST) begin stb_d = 1'b1; cnt_d = '0; st_d = GAP; end
            else cnt_d = cnt_q + 1'b1;
         end
         GAP: begin
            if (cnt_q != GAP_LAST) cnt_d = cnt_q + 1'b1;
            else if (txn_q == 2'd2) begin
               cnt_d = '0; busy_d = 1'b0; st_d = IDLE;
            end else begin
               cnt_d = '0; txn_d = txn_q + 2'd1; byte_d = 5'd0; stb_d = 1'b0; st_d = STB_SETUP;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_50M) begin
      if (reset) begin
         st_q <= IDLE;  cnt_q <= '0;  bit_q <= 3'd0;  ph_q <= 1'b0;
         txn_q <= 2'd0; byte_q <= 5'd0; ref_q <= '0;  first_q <= 1'b1;
         stb_q <= 1'b1; sclk_q <= 1'b1; dio_q <= 1'b0; busy_q <= 1'b0;
         dchk_q <= 8'h00;
      end else begin
         st_q <= st_d;   cnt_q <= cnt_d;   bit_q <= bit_d;   ph_q <= ph_d;
         txn_q <= txn_d; byte_q <= byte_d; ref_q <= ref_d;   first_q <= first_d;
         stb_q <= stb_d; sclk_q <= sclk_d; dio_q <= dio_d;   busy_q <= busy_d;
         dchk_q <= dchk_d;
      end
   end

   always_ff @(posedge clk_50M) begin
      sh_q <= sh_d;
      if (start) begin
         hc_q <= bus.hour_chuc; hd_q <= bus.hour_dv;
         mc_q <= bus.min_chuc;  md_q <= bus.min_dv;
         sc_q <= bus.sec_chuc;  sd_q <= bus.sec_dv;
      end
   end

   assign bus.stb        = stb_q;
   assign bus.sclk       = sclk_q;
   assign bus.dio        = dio_q;
   assign bus.busy       = busy_q;
   assign bus.data_check = dchk_q;
endmodule

// File: tb/tb_tm1638_disp_drv.sv
// Directed bench for tm1638_disp_drv: decodes the serial bus and checks frames against tables.
module tb_tm1638_disp_drv;
   localparam int CLK_DIV = 2;
   localparam int REFRESH = 2000;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [7:0] HC0 = 8'h00;
`else
   localparam logic [7:0] HC0 = 8'h3F;
`endif

   typedef struct packed {
      logic [23:0] digits;
      logic [63:0] segs;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #10 clk = ~clk;

   tm1638_disp_drv_if bus();

   tm1638_disp_drv #(
      .CLK_DIV(CLK_DIV), .REFRESH_CYCLES(REFRESH), .BRIGHTNESS(3'd7)
   ) dut (
      .clk_50M(clk), .reset(reset), .bus(bus)
   );

   int n_checks = 0;
   int n_fail = 0;
   int pcyc = 0;
   logic [7:0] rx_bytes[$];
   int rx_wins[$];
   int idx_b, idx_w, start_cyc, prev_start;
   int dio_bad = 0, per_bad = 0, bitc = 0, wbytes = 0, wrises = 0, last_rise = 0;
   logic pstb = 1'b1, psclk = 1'b1, pdio = 1'b0;
   logic [7:0] shreg = 8'h00;
   vec_t vecs[6];

   always @(posedge clk) pcyc <= pcyc + 1;

   // serial-bus decoder: bits on rising sclk while stb is low, byte count per stb window
   always @(negedge clk) begin
      if (pstb && !bus.stb) begin bitc = 0; wbytes = 0; wrises = 0; end
      if (!pstb && bus.stb) rx_wins.push_back(wbytes);
      if (!bus.stb && !psclk && bus.sclk) begin
         if (bus.dio !== pdio) dio_bad++;
         if (wrises > 0 && (pcyc - last_rise) != 2 * CLK_DIV) per_bad++;
         last_rise = pcyc;
         wrises++;
         shreg = {bus.dio, shreg[7:1]};
         bitc++;
         if (bitc == 8) begin rx_bytes.push_back(shreg); bitc = 0; wbytes++; end
      end
      pstb = bus.stb; psclk = bus.sclk; pdio = bus.dio;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_digits(input logic [23:0] d);
      bus.hour_chuc = d[23:20]; bus.hour_dv = d[19:16];
      bus.min_chuc  = d[15:12]; bus.min_dv  = d[11:8];
      bus.sec_chuc  = d[7:4];   bus.sec_dv  = d[3:0];
   endtask

   task automatic wait_start();
      int n = 0;
      while (bus.busy !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
      check("frame_start_seen", int'(bus.busy), 1);
      idx_b = rx_bytes.size();
      idx_w = rx_wins.size();
      start_cyc = pcyc;
   endtask

   task automatic finish_frame(input logic [63:0] segs, input string tag);
      int n = 0;
      int nb, nw, e, a;
      while (bus.busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      check({tag, "_frame_end"}, int'(bus.busy), 0);
      check({tag, "_data_check"}, int'(bus.data_check), 'h8F);
      nb = rx_bytes.size() - idx_b;
      nw = rx_wins.size() - idx_w;
      check({tag, "_nbytes"}, nb, 19);
      check({tag, "_nwindows"}, nw, 3);
      if (nb == 19 && nw == 3) begin
         for (int k = 0; k < 19; k++) begin
            if (k == 0)       e = 'h40;
            else if (k == 1)  e = 'hC0;
            else if (k == 18) e = 'h8F;
            else begin
               a = k - 2;
               e = (a % 2 == 1) ? 0 : int'(segs[63 - 8 * (a / 2) -: 8]);
            end
            check($sformatf("%s_byte%0d", tag, k), int'(rx_bytes[idx_b + k]), e);
         end
         check({tag, "_win_T1"}, rx_wins[idx_w], 1);
         check({tag, "_win_T2"}, rx_wins[idx_w + 1], 17);
         check({tag, "_win_T3"}, rx_wins[idx_w + 2], 1);
      end
   endtask

   initial begin
      vecs[0] = '{24'h123456, 64'h065B404F66406D7D};
      vecs[1] = '{24'hA00000, 64'h403F403F3F403F3F};
      vecs[2] = '{24'h000000, {HC0, 56'h3F403F3F403F3F}};
      vecs[3] = '{24'h235959, 64'h5B4F406D6F406D6F};
      vecs[4] = '{24'h190807, 64'h066F403F7F403F07};
      vecs[5] = '{24'hBCDEF9, 64'h404040404040406F};

      set_digits(24'h123456);
      repeat (3) @(negedge clk);
      check("rst_stb", int'(bus.stb), 1);
      check("rst_sclk", int'(bus.sclk), 1);
      check("rst_dio", int'(bus.dio), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_data_check", int'(bus.data_check), 0);

      reset = 1'b0;
      @(negedge clk);
      check("stb_fall_1cyc", int'(bus.stb), 0);
      check("busy_rise_1cyc", int'(bus.busy), 1);
      wait_start();
      prev_start = start_cyc;
      finish_frame(vecs[0].segs, "init");

      for (int i = 0; i < 6; i++) begin
         set_digits(vecs[i].digits);
         wait_start();
         check($sformatf("spacing_v%0d", i), start_cyc - prev_start, REFRESH);
         prev_start = start_cyc;
         finish_frame(vecs[i].segs, $sformatf("v%0d", i));
         repeat (100) @(negedge clk);
         check($sformatf("idle_busy_v%0d", i), int'(bus.busy), 0);
         check($sformatf("idle_stb_v%0d", i), int'(bus.stb), 1);
         check($sformatf("idle_sclk_v%0d", i), int'(bus.sclk), 1);
      end

      // digit change in the middle of T2 must only show in the following frame
      set_digits(24'h123456);
      wait_start();
      check("spacing_mid", start_cyc - prev_start, REFRESH);
      prev_start = start_cyc;
      repeat (100) @(negedge clk);
      bus.sec_dv = 4'd7;
      finish_frame(64'h065B404F66406D7D, "mid_cur");
      wait_start();
      check("spacing_next", start_cyc - prev_start, REFRESH);
      finish_frame(64'h065B404F66406D07, "mid_next");

      // reset during bit 3 of the address-0 data byte (cycle 86 after frame start)
      wait_start();
      repeat (86) @(negedge clk);
      check("pre_rst_sclk_low", int'(bus.sclk), 0);
      check("pre_rst_bytes", rx_bytes.size() - idx_b, 2);
      reset = 1'b1;
      @(negedge clk);
      check("abort_stb", int'(bus.stb), 1);
      check("abort_sclk", int'(bus.sclk), 1);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_dio", int'(bus.dio), 0);
      check("abort_data_check", int'(bus.data_check), 0);
      reset = 1'b0;
      @(negedge clk);
      check("restart_stb", int'(bus.stb), 0);
      check("restart_busy", int'(bus.busy), 1);
      wait_start();
      finish_frame(64'h065B404F66406D07, "post_rst");

      check("dio_stable_at_rise", dio_bad, 0);
      check("sclk_period", per_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
